// File: rtl/sq_cmd_queue_pkg.sv
// ============================================================================
// Module      : sq_cmd_queue_pkg
// Description : Shared widths and the FIFO entry layout for the storage queue.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package sq_cmd_queue_pkg;

    localparam int SQ_DESC_W  = 256;
    localparam int SQ_INDEX_W = 8;

    typedef struct packed {
        logic [SQ_DESC_W-1:0]  desc;
        logic [SQ_INDEX_W-1:0] index;
    } sq_entry_t;

    localparam int SQ_ENTRY_W = $bits(sq_entry_t);

endpackage

`default_nettype wire

// File: rtl/sq_fifo.sv
// ============================================================================
// Module      : sq_fifo
// Description : Synchronous FIFO; head data is valid whenever not empty.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sq_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 264
) (
    input  logic                     clock_fpga,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // Full/empty come from the occupancy count; pointers wrap naturally.
    assign full     = (r_count == CNT_W'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign pop_data = r_mem[r_rd_ptr];
    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;

    always_ff @(posedge clock_fpga) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock_fpga) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/sq_cmd_queue.sv
// ============================================================================
// Module      : sq_cmd_queue
// Description : Storage-side command queue: buffers descriptors, issues them
//               to the back-end and reports completions back to the ifq.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sq_cmd_queue
    import sq_cmd_queue_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int OUTSTANDING = 4,
    parameter int SLOT_W      = 2
) (
    input  logic                    clock_fpga,
    input  logic                    reset,
    input  logic                    sq_select,
    input  logic [SQ_DESC_W-1:0]    cmd_in,
    input  logic [SQ_INDEX_W-1:0]   cmd_index_in,
    output logic                    sq_full,
    output logic [$clog2(DEPTH):0]  sq_count,
    output logic                    dev_cmd_valid,
    input  logic                    dev_cmd_ready,
    output logic [SQ_DESC_W-1:0]    dev_cmd,
    output logic [SLOT_W-1:0]       dev_slot,
    input  logic                    dev_done,
    input  logic [SLOT_W-1:0]       dev_done_slot,
    output logic                    status_update_enable,
    output logic [SQ_INDEX_W-1:0]   cmdq_index,
    output logic                    err_overflow,
    output logic                    err_bad_done
);

    sq_entry_t               w_push_entry;
    sq_entry_t               w_head;
    logic [SQ_ENTRY_W-1:0]   w_head_raw;
    logic                    w_fifo_empty;
    logic                    w_fifo_full;

    logic                    r_valid;
    logic [SQ_DESC_W-1:0]    r_dev_cmd;
    logic [SLOT_W-1:0]       r_slot;

    logic [OUTSTANDING-1:0]  r_busy;
    logic [SQ_INDEX_W-1:0]   r_slot_index [OUTSTANDING];

    logic                    r_status;
    logic [SQ_INDEX_W-1:0]   r_cmdq_index;
    logic                    r_err_overflow;
    logic                    r_err_bad_done;

    logic                    w_free_found;
    logic [SLOT_W-1:0]       w_free_slot;
    logic                    w_done_busy;
    logic [SQ_INDEX_W-1:0]   w_done_index;
    logic                    w_done_ok;
    logic                    w_load;

    assign w_push_entry.desc  = cmd_in;
    assign w_push_entry.index = cmd_index_in;
    assign w_head             = w_head_raw;

    sq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SQ_ENTRY_W)
    ) u_fifo (
        .clock_fpga (clock_fpga),
        .reset      (reset),
        .push       (sq_select),
        .push_data  (w_push_entry),
        .pop        (w_load),
        .pop_data   (w_head_raw),
        .full       (w_fifo_full),
        .empty      (w_fifo_empty),
        .count      (sq_count)
    );

    // Lowest-index free slot wins: scan downward so the last hit is the lowest.
    always_comb begin
        w_free_found = 1'b0;
        w_free_slot  = '0;
        for (int i = OUTSTANDING - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_found = 1'b1;
                w_free_slot  = SLOT_W'(i);
            end
        end
    end

    always_comb begin
        w_done_busy  = 1'b0;
        w_done_index = '0;
        for (int i = 0; i < OUTSTANDING; i++) begin
            if (dev_done_slot == SLOT_W'(i)) begin
                w_done_busy  = r_busy[i];
                w_done_index = r_slot_index[i];
            end
        end
    end

    // A slot still sitting in the offer register has not reached the back-end.
    assign w_done_ok = dev_done && w_done_busy && !(r_valid && (r_slot == dev_done_slot));
    assign w_load    = !w_fifo_empty && w_free_found && (!r_valid || dev_cmd_ready);

    always_ff @(posedge clock_fpga) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_dev_cmd <= '0;
            r_slot    <= '0;
        end else if (w_load) begin
            r_valid   <= 1'b1;
            r_dev_cmd <= w_head.desc;
            r_slot    <= w_free_slot;
        end else if (dev_cmd_ready) begin
            r_valid   <= 1'b0;
        end
    end

    // Allocation and completion never target the same slot: one needs it free,
    // the other busy, both judged on the pre-edge map.
    always_ff @(posedge clock_fpga) begin
        if (reset) begin
            r_busy <= '0;
            for (int i = 0; i < OUTSTANDING; i++) r_slot_index[i] <= '0;
        end else begin
            for (int i = 0; i < OUTSTANDING; i++) begin
                if (w_load && (w_free_slot == SLOT_W'(i))) begin
                    r_busy[i]       <= 1'b1;
                    r_slot_index[i] <= w_head.index;
                end else if (w_done_ok && (dev_done_slot == SLOT_W'(i))) begin
                    r_busy[i]       <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock_fpga) begin
        if (reset) begin
            r_status       <= 1'b0;
            r_cmdq_index   <= '0;
            r_err_overflow <= 1'b0;
            r_err_bad_done <= 1'b0;
        end else begin
            r_status       <= w_done_ok;
            r_cmdq_index   <= w_done_ok ? w_done_index : '0;
            r_err_overflow <= r_err_overflow | (sq_select & w_fifo_full);
            r_err_bad_done <= r_err_bad_done | (dev_done & !w_done_ok);
        end
    end

    assign sq_full              = w_fifo_full;
    assign dev_cmd_valid        = r_valid;
    assign dev_cmd              = r_dev_cmd;
    assign dev_slot             = r_slot;
    assign status_update_enable = r_status;
    assign cmdq_index           = r_cmdq_index;
    assign err_overflow         = r_err_overflow;
    assign err_bad_done         = r_err_bad_done;

endmodule

`default_nettype wire

// File: tb/tb_sq_cmd_queue.sv
// ============================================================================
// Module      : tb_sq_cmd_queue
// Description : Directed self-checking bench for sq_cmd_queue.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sq_cmd_queue;

    localparam int DEPTH       = 8;
    localparam int OUTSTANDING = 4;
    localparam int SLOT_W      = 2;

    logic          clock_fpga = 1'b0;
    logic          reset;
    logic          sq_select;
    logic [255:0]  cmd_in;
    logic [7:0]    cmd_index_in;
    logic          sq_full;
    logic [3:0]    sq_count;
    logic          dev_cmd_valid;
    logic          dev_cmd_ready;
    logic [255:0]  dev_cmd;
    logic [1:0]    dev_slot;
    logic          dev_done;
    logic [1:0]    dev_done_slot;
    logic          status_update_enable;
    logic [7:0]    cmdq_index;
    logic          err_overflow;
    logic          err_bad_done;

    int checks   = 0;
    int failures = 0;

    logic [1:0]    acc_slot_q [$];
    logic [255:0]  acc_desc_q [$];
    logic [7:0]    pulse_q    [$];

    sq_cmd_queue #(
        .DEPTH       (DEPTH),
        .OUTSTANDING (OUTSTANDING),
        .SLOT_W      (SLOT_W)
    ) dut (
        .clock_fpga           (clock_fpga),
        .reset                (reset),
        .sq_select            (sq_select),
        .cmd_in               (cmd_in),
        .cmd_index_in         (cmd_index_in),
        .sq_full              (sq_full),
        .sq_count             (sq_count),
        .dev_cmd_valid        (dev_cmd_valid),
        .dev_cmd_ready        (dev_cmd_ready),
        .dev_cmd              (dev_cmd),
        .dev_slot             (dev_slot),
        .dev_done             (dev_done),
        .dev_done_slot        (dev_done_slot),
        .status_update_enable (status_update_enable),
        .cmdq_index           (cmdq_index),
        .err_overflow         (err_overflow),
        .err_bad_done         (err_bad_done)
    );

    always #5 clock_fpga = ~clock_fpga;

    // Log every handshake and completion pulse as seen at the clock edge.
    always @(posedge clock_fpga) begin
        if (dev_cmd_valid && dev_cmd_ready) begin
            acc_slot_q.push_back(dev_slot);
            acc_desc_q.push_back(dev_cmd);
        end
        if (status_update_enable) pulse_q.push_back(cmdq_index);
    end

    function automatic logic [255:0] mk_desc(input logic [7:0] t);
        return {32{t}} ^ {8{32'hA5C3_0F96}};
    endfunction

    task automatic tick();
        @(posedge clock_fpga);
        #1;
    endtask

    task automatic push_one(input logic [7:0] t);
        sq_select    = 1'b1;
        cmd_in       = mk_desc(t);
        cmd_index_in = t;
        tick();
        sq_select    = 1'b0;
    endtask

    task automatic apply_reset();
        reset         = 1'b1;
        sq_select     = 1'b0;
        cmd_in        = '0;
        cmd_index_in  = '0;
        dev_cmd_ready = 1'b0;
        dev_done      = 1'b0;
        dev_done_slot = '0;
        tick();
        reset = 1'b0;
        acc_slot_q.delete();
        acc_desc_q.delete();
        pulse_q.delete();
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        sq_select     = 1'b0;
        cmd_in        = '0;
        cmd_index_in  = '0;
        dev_cmd_ready = 1'b0;
        dev_done      = 1'b0;
        dev_done_slot = '0;
        tick();
        tick();
        checks++;
        if ({dev_cmd_valid, sq_full, status_update_enable, err_overflow, err_bad_done} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {dev_cmd_valid, sq_full, status_update_enable, err_overflow, err_bad_done});
        end
        checks++;
        if (sq_count !== 4'd0) begin
            failures++; $display("FAIL reset_count: got %0d expected 0", sq_count);
        end
        checks++;
        if (dev_cmd !== 256'd0) begin
            failures++; $display("FAIL reset_dev_cmd: got %h expected 0", dev_cmd);
        end
        checks++;
        if ({dev_slot, cmdq_index} !== 10'd0) begin
            failures++; $display("FAIL reset_slot_index: got %h expected 0", {dev_slot, cmdq_index});
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        apply_reset();
        dev_cmd_ready = 1'b1;
        push_one(8'h05);
        checks++;
        if (dev_cmd_valid !== 1'b0) begin
            failures++; $display("FAIL t1_early_valid: got %b expected 0", dev_cmd_valid);
        end
        tick();
        checks++;
        if ({dev_cmd_valid, dev_slot, dev_cmd} !== {1'b1, 2'd0, mk_desc(8'h05)}) begin
            failures++;
            $display("FAIL t1_offer: got valid=%b slot=%0d cmd=%h expected valid=1 slot=0 cmd=%h",
                     dev_cmd_valid, dev_slot, dev_cmd, mk_desc(8'h05));
        end
        tick();
        checks++;
        if (dev_cmd_valid !== 1'b0) begin
            failures++; $display("FAIL t1_valid_drop: got %b expected 0", dev_cmd_valid);
        end
        dev_done      = 1'b1;
        dev_done_slot = 2'd0;
        tick();
        dev_done = 1'b0;
        checks++;
        if ({status_update_enable, cmdq_index} !== {1'b1, 8'h05}) begin
            failures++;
            $display("FAIL t1_pulse: got en=%b idx=%h expected en=1 idx=05", status_update_enable, cmdq_index);
        end
        tick();
        checks++;
        if ({status_update_enable, err_bad_done} !== 2'b00) begin
            failures++;
            $display("FAIL t1_pulse_end: got en=%b bad=%b expected 0 0", status_update_enable, err_bad_done);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        push_one(8'h10);
        push_one(8'h11);
        push_one(8'h12);
        checks++;
        if (sq_count !== 4'd2) begin
            failures++; $display("FAIL t2_count: got %0d expected 2", sq_count);
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({dev_cmd_valid, dev_slot, dev_cmd} !== {1'b1, 2'd0, mk_desc(8'h10)}) begin
                failures++;
                $display("FAIL t2_hold: got valid=%b slot=%0d cmd=%h expected valid=1 slot=0 cmd=%h",
                         dev_cmd_valid, dev_slot, dev_cmd, mk_desc(8'h10));
            end
            tick();
        end
        dev_cmd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({dev_cmd_valid, dev_slot, dev_cmd} !== {1'b1, SLOT_W'(i), mk_desc(8'(16 + i))}) begin
                failures++;
                $display("FAIL t2_issue: got valid=%b slot=%0d cmd=%h expected valid=1 slot=%0d cmd=%h",
                         dev_cmd_valid, dev_slot, dev_cmd, i, mk_desc(8'(16 + i)));
            end
            tick();
        end
        checks++;
        if ({dev_cmd_valid, 32'(acc_slot_q.size())} !== {1'b0, 32'd3}) begin
            failures++;
            $display("FAIL t2_done_issuing: got valid=%b accepted=%0d expected valid=0 accepted=3",
                     dev_cmd_valid, acc_slot_q.size());
        end
    endtask

    task automatic test_exhaustion();
        apply_reset();
        dev_cmd_ready = 1'b1;
        for (int i = 0; i < 6; i++) push_one(8'(32 + i));
        repeat (4) tick();
        checks++;
        if (acc_slot_q.size() != 4) begin
            failures++; $display("FAIL t3_issued: got %0d expected 4", acc_slot_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ({acc_slot_q[i], acc_desc_q[i]} !== {SLOT_W'(i), mk_desc(8'(32 + i))}) begin
                    failures++;
                    $display("FAIL t3_order: item %0d got slot=%0d cmd=%h expected slot=%0d cmd=%h",
                             i, acc_slot_q[i], acc_desc_q[i], i, mk_desc(8'(32 + i)));
                end
            end
        end
        checks++;
        if ({sq_count, dev_cmd_valid} !== {4'd2, 1'b0}) begin
            failures++;
            $display("FAIL t3_stall: got count=%0d valid=%b expected count=2 valid=0", sq_count, dev_cmd_valid);
        end
        dev_done      = 1'b1;
        dev_done_slot = 2'd2;
        tick();
        dev_done = 1'b0;
        checks++;
        if ({status_update_enable, cmdq_index} !== {1'b1, 8'h22}) begin
            failures++;
            $display("FAIL t3_pulse: got en=%b idx=%h expected en=1 idx=22", status_update_enable, cmdq_index);
        end
        tick();
        checks++;
        if ({dev_cmd_valid, dev_slot, dev_cmd} !== {1'b1, 2'd2, mk_desc(8'h24)}) begin
            failures++;
            $display("FAIL t3_reuse: got valid=%b slot=%0d cmd=%h expected valid=1 slot=2 cmd=%h",
                     dev_cmd_valid, dev_slot, dev_cmd, mk_desc(8'h24));
        end
    endtask

    task automatic test_overflow();
        int n_done;
        apply_reset();
        for (int i = 0; i < DEPTH + 2; i++) push_one(8'(48 + i));
        checks++;
        if ({sq_full, err_overflow, sq_count} !== {1'b1, 1'b1, 4'd8}) begin
            failures++;
            $display("FAIL t4_full: got full=%b ovf=%b count=%0d expected full=1 ovf=1 count=8",
                     sq_full, err_overflow, sq_count);
        end
        dev_cmd_ready = 1'b1;
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            if (acc_slot_q.size() > n_done) begin
                dev_done      = 1'b1;
                dev_done_slot = acc_slot_q[n_done];
                n_done++;
            end else begin
                dev_done = 1'b0;
            end
            tick();
        end
        dev_done = 1'b0;
        tick();
        tick();
        checks++;
        if (acc_desc_q.size() != DEPTH + 1) begin
            failures++; $display("FAIL t4_issued: got %0d expected %0d", acc_desc_q.size(), DEPTH + 1);
        end else begin
            for (int i = 0; i < DEPTH + 1; i++) begin
                checks++;
                if (acc_desc_q[i] !== mk_desc(8'(48 + i))) begin
                    failures++;
                    $display("FAIL t4_order: item %0d got %h expected %h", i, acc_desc_q[i], mk_desc(8'(48 + i)));
                end
            end
        end
        checks++;
        if (pulse_q.size() != DEPTH + 1) begin
            failures++; $display("FAIL t4_pulses: got %0d expected %0d", pulse_q.size(), DEPTH + 1);
        end else begin
            for (int i = 0; i < DEPTH + 1; i++) begin
                checks++;
                if (pulse_q[i] !== 8'(48 + i)) begin
                    failures++;
                    $display("FAIL t4_pulse_idx: item %0d got %h expected %h", i, pulse_q[i], 8'(48 + i));
                end
            end
        end
        checks++;
        if ({err_overflow, err_bad_done, sq_count} !== {1'b1, 1'b0, 4'd0}) begin
            failures++;
            $display("FAIL t4_final: got ovf=%b bad=%b count=%0d expected ovf=1 bad=0 count=0",
                     err_overflow, err_bad_done, sq_count);
        end
    endtask

    task automatic test_bad_done();
        apply_reset();
        dev_done      = 1'b1;
        dev_done_slot = 2'd3;
        tick();
        dev_done = 1'b0;
        checks++;
        if ({status_update_enable, err_bad_done} !== 2'b01) begin
            failures++;
            $display("FAIL t5_free_slot: got en=%b bad=%b expected en=0 bad=1", status_update_enable, err_bad_done);
        end
        push_one(8'h41);
        tick();
        checks++;
        if ({dev_cmd_valid, dev_slot} !== {1'b1, 2'd0}) begin
            failures++;
            $display("FAIL t5_alloc: got valid=%b slot=%0d expected valid=1 slot=0", dev_cmd_valid, dev_slot);
        end
        dev_done      = 1'b1;
        dev_done_slot = 2'd0;
        tick();
        dev_done = 1'b0;
        checks++;
        if ({status_update_enable, dev_cmd_valid, dev_slot} !== {1'b0, 1'b1, 2'd0}) begin
            failures++;
            $display("FAIL t5_offer_slot: got en=%b valid=%b slot=%0d expected en=0 valid=1 slot=0",
                     status_update_enable, dev_cmd_valid, dev_slot);
        end
        dev_cmd_ready = 1'b1;
        tick();
        dev_done      = 1'b1;
        dev_done_slot = 2'd0;
        tick();
        dev_done = 1'b0;
        checks++;
        if ({status_update_enable, cmdq_index} !== {1'b1, 8'h41}) begin
            failures++;
            $display("FAIL t5_table_intact: got en=%b idx=%h expected en=1 idx=41", status_update_enable, cmdq_index);
        end
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        dev_cmd_ready = 1'b1;
        push_one(8'h50);
        push_one(8'h51);
        push_one(8'h52);
        repeat (3) tick();
        dev_cmd_ready = 1'b0;
        push_one(8'h53);
        push_one(8'h54);
        checks++;
        if ({32'(acc_slot_q.size()), sq_count, dev_cmd_valid} !== {32'd3, 4'd1, 1'b1}) begin
            failures++;
            $display("FAIL t6_setup: got accepted=%0d count=%0d valid=%b expected 3 1 1",
                     acc_slot_q.size(), sq_count, dev_cmd_valid);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({dev_cmd_valid, sq_full, status_update_enable, err_overflow, err_bad_done,
             dev_slot, cmdq_index, sq_count} !== 21'd0) begin
            failures++;
            $display("FAIL t6_reset_outputs: got valid=%b full=%b en=%b ovf=%b bad=%b slot=%0d idx=%h count=%0d expected all 0",
                     dev_cmd_valid, sq_full, status_update_enable, err_overflow, err_bad_done,
                     dev_slot, cmdq_index, sq_count);
        end
        checks++;
        if (dev_cmd !== 256'd0) begin
            failures++; $display("FAIL t6_reset_cmd: got %h expected 0", dev_cmd);
        end
        pulse_q.delete();
        dev_cmd_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (dev_cmd_valid !== 1'b0) begin
            failures++; $display("FAIL t6_no_offer: got %b expected 0", dev_cmd_valid);
        end
        dev_done      = 1'b1;
        dev_done_slot = 2'd1;
        tick();
        dev_done = 1'b0;
        tick();
        checks++;
        if ({32'(pulse_q.size()), err_bad_done} !== {32'd0, 1'b1}) begin
            failures++;
            $display("FAIL t6_stale_done: got pulses=%0d bad=%b expected pulses=0 bad=1", pulse_q.size(), err_bad_done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_exhaustion();
        test_overflow();
        test_bad_done();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
